// File: rtl/arm_pkg.sv
// Shared ARM core constants: datapath widths and the
// architectural register numbers with special meaning.
package arm_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 4;
    localparam int NUM_REGS   = 16;

    localparam logic [3:0] REG_PC = 4'd15;
    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_SP = 4'd13;

endpackage

// File: rtl/writeback_mux.sv
// Writeback value select: load data or ALU result.
// Shared with the forwarding unit.
module writeback_mux #(
    parameter int WIDTH = 32
) (
    input  logic             select,
    input  logic [WIDTH-1:0] mem_data,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] wb_data
);

    assign wb_data = select ? mem_data : alu_result;

endmodule

// File: rtl/wb_register_file.sv
// ARM register file with integrated writeback: R0-R14 storage,
// R15 reads return PC+8, R15 writes become a PC-redirect pulse.
module wb_register_file
    import arm_pkg::*;
#(
    parameter int DATA_WIDTH = arm_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = arm_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = arm_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write_enable_in,
    input  logic                  mem_to_reg_select_in,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] pc_plus8,
    input  logic [ADDR_WIDTH-1:0] rn_addr,
    input  logic [ADDR_WIDTH-1:0] rm_addr,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    output logic [DATA_WIDTH-1:0] rn_data,
    output logic [DATA_WIDTH-1:0] rm_data,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  pc_write_valid,
    output logic [DATA_WIDTH-1:0] pc_write_data
);

    localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(REG_PC);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS-1];
    logic                  wr_gpr;
    logic                  wr_pc;

    writeback_mux #(
        .WIDTH(DATA_WIDTH)
    ) u_wb_mux (
        .select    (mem_to_reg_select_in),
        .mem_data  (mem_data),
        .alu_result(alu_result),
        .wb_data   (wb_data)
    );

    assign wr_pc  = reg_write_enable_in && (wb_addr == PC_ADDR);
    assign wr_gpr = reg_write_enable_in && (wb_addr != PC_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_gpr) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // pc_write_data only moves on a redirect so fetch sees a stable value
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_write_valid <= 1'b0;
            pc_write_data  <= '0;
        end else begin
            pc_write_valid <= wr_pc;
            if (wr_pc) begin
                pc_write_data <= wb_data;
            end
        end
    end

    // PC first, then same-cycle bypass, then the array
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] addr
    );
        logic [DATA_WIDTH-1:0] val;
        if (addr == PC_ADDR) begin
            val = pc_plus8;
        end else if (reg_write_enable_in && (addr == wb_addr)) begin
            val = wb_data;
        end else begin
            val = regs[addr];
        end
        return val;
    endfunction

    assign rn_data = read_port(rn_addr);
    assign rm_data = read_port(rm_addr);
    assign rs_data = read_port(rs_addr);

endmodule

// File: tb/tb_wb_register_file.sv
// Directed-vector bench for wb_register_file: table of per-cycle
// stimulus and expected outputs, plus a fill/readback sequence.
module tb_wb_register_file;

    logic        clk;
    logic        reset;
    logic        we;
    logic        sel;
    logic [3:0]  wa;
    logic [31:0] mem_data;
    logic [31:0] alu_result;
    logic [31:0] pc_plus8;
    logic [3:0]  rn_addr;
    logic [3:0]  rm_addr;
    logic [3:0]  rs_addr;
    logic [31:0] rn_data;
    logic [31:0] rm_data;
    logic [31:0] rs_data;
    logic [31:0] wb_data;
    logic        pc_write_valid;
    logic [31:0] pc_write_data;

    wb_register_file dut (
        .clk                 (clk),
        .reset               (reset),
        .reg_write_enable_in (we),
        .mem_to_reg_select_in(sel),
        .wb_addr             (wa),
        .mem_data            (mem_data),
        .alu_result          (alu_result),
        .pc_plus8            (pc_plus8),
        .rn_addr             (rn_addr),
        .rm_addr             (rm_addr),
        .rs_addr             (rs_addr),
        .rn_data             (rn_data),
        .rm_data             (rm_data),
        .rs_data             (rs_data),
        .wb_data             (wb_data),
        .pc_write_valid      (pc_write_valid),
        .pc_write_data       (pc_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic        rst;
        logic        we;
        logic        sel;
        logic [3:0]  wa;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [31:0] pc8;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic [31:0] ern;
        logic [31:0] erm;
        logic [31:0] ers;
        logic [31:0] ewb;
        logic        epv;
        logic [31:0] epd;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    task automatic v(
        input logic        chk,
        input logic        rst,
        input logic        we_i,
        input logic        sel_i,
        input logic [3:0]  wa_i,
        input logic [31:0] mem,
        input logic [31:0] alu,
        input logic [31:0] pc8,
        input logic [3:0]  rn,
        input logic [3:0]  rm,
        input logic [3:0]  rs,
        input logic [31:0] ern,
        input logic [31:0] erm,
        input logic [31:0] ers,
        input logic [31:0] ewb,
        input logic        epv,
        input logic [31:0] epd
    );
        vec_t t;
        t = '{chk, rst, we_i, sel_i, wa_i, mem, alu, pc8,
              rn, rm, rs, ern, erm, ers, ewb, epv, epd};
        vecs.push_back(t);
    endtask

    task automatic check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        reset      = t.rst;
        we         = t.we;
        sel        = t.sel;
        wa         = t.wa;
        mem_data   = t.mem;
        alu_result = t.alu;
        pc_plus8   = t.pc8;
        rn_addr    = t.rn;
        rm_addr    = t.rm;
        rs_addr    = t.rs;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset = 1'b1; we = 1'b0; sel = 1'b0; wa = 4'd0;
        mem_data = '0; alu_result = '0; pc_plus8 = 32'h1008;
        rn_addr = 4'd0; rm_addr = 4'd1; rs_addr = 4'd2;

        // chk rst we sel wa mem alu pc8 rn rm rs | ern erm ers ewb epv epd
        v(0,1,0,0, 0, 0, 0, 32'h1008, 0, 1, 2,
          0, 0, 0, 0, 0, 0);
        v(1,1,0,0, 0, 0, 0, 32'h1008, 0, 1, 2,
          0, 0, 0, 0, 0, 0);
        v(1,0,0,0, 0, 0, 0, 32'h1008, 13, 14, 15,
          0, 0, 32'h1008, 0, 0, 0);
        v(1,0,1,0, 3, 32'h11111111, 32'hDEADBEEF, 32'h1008, 3, 4, 15,
          32'hDEADBEEF, 0, 32'h1008, 32'hDEADBEEF, 0, 0);
        v(1,0,0,0, 3, 0, 0, 32'h1008, 3, 3, 0,
          32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0);
        v(1,0,1,1, 7, 32'hA5, 32'hFFFF0000, 32'h1008, 7, 7, 7,
          32'hA5, 32'hA5, 32'hA5, 32'hA5, 0, 0);
        v(1,0,0,0, 7, 0, 0, 32'h1008, 7, 3, 6,
          32'hA5, 32'hDEADBEEF, 0, 0, 0, 0);
        v(1,0,1,0, 15, 0, 32'h2000, 32'h1008, 15, 3, 7,
          32'h1008, 32'hDEADBEEF, 32'hA5, 32'h2000, 0, 0);
        v(1,0,0,0, 15, 0, 0, 32'h1008, 15, 7, 0,
          32'h1008, 32'hA5, 0, 0, 1, 32'h2000);
        v(1,0,0,0, 15, 0, 0, 32'h1008, 3, 7, 0,
          32'hDEADBEEF, 32'hA5, 0, 0, 0, 32'h2000);
        v(1,0,1,0, 15, 0, 32'h3000, 32'h2008, 15, 3, 1,
          32'h2008, 32'hDEADBEEF, 0, 32'h3000, 0, 32'h2000);
        v(1,0,1,0, 15, 0, 32'h4000, 32'h2008, 15, 3, 1,
          32'h2008, 32'hDEADBEEF, 0, 32'h4000, 1, 32'h3000);
        v(1,0,0,0, 0, 0, 0, 32'h2008, 15, 7, 1,
          32'h2008, 32'hA5, 0, 0, 1, 32'h4000);
        v(1,0,0,0, 0, 0, 0, 32'h2008, 15, 7, 1,
          32'h2008, 32'hA5, 0, 0, 0, 32'h4000);
        v(1,0,0,0, 5, 0, 32'hFFFFFFFF, 32'h2008, 5, 15, 3,
          0, 32'h2008, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 32'h4000);
        v(1,0,0,0, 5, 0, 32'hFFFFFFFF, 32'h2008, 5, 5, 5,
          0, 0, 0, 32'hFFFFFFFF, 0, 32'h4000);
        v(1,0,1,0, 14, 0, 32'hCAFE0001, 32'h2008, 14, 13, 14,
          32'hCAFE0001, 0, 32'hCAFE0001, 32'hCAFE0001, 0, 32'h4000);
        v(1,0,0,0, 14, 0, 0, 32'h2008, 14, 3, 7,
          32'hCAFE0001, 32'hDEADBEEF, 32'hA5, 0, 0, 32'h4000);
        v(1,1,1,0, 2, 0, 32'h12345678, 32'h2008, 2, 3, 15,
          32'h12345678, 32'hDEADBEEF, 32'h2008, 32'h12345678, 0, 32'h4000);
        v(1,0,0,0, 2, 0, 0, 32'h2008, 2, 3, 14,
          0, 0, 0, 0, 0, 0);
        v(1,0,1,0, 15, 0, 32'h5000, 32'h2008, 15, 7, 2,
          32'h2008, 0, 0, 32'h5000, 0, 0);
        v(1,1,1,0, 15, 0, 32'h6000, 32'h2008, 15, 7, 2,
          32'h2008, 0, 0, 32'h6000, 1, 32'h5000);
        v(1,0,0,0, 15, 0, 0, 32'h2008, 15, 7, 2,
          32'h2008, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            if (vecs[i].chk) begin
                check($sformatf("v%0d rn", i), rn_data, vecs[i].ern);
                check($sformatf("v%0d rm", i), rm_data, vecs[i].erm);
                check($sformatf("v%0d rs", i), rs_data, vecs[i].ers);
                check($sformatf("v%0d wb", i), wb_data, vecs[i].ewb);
                check($sformatf("v%0d pcv", i),
                      {31'd0, pc_write_valid}, {31'd0, vecs[i].epv});
                check($sformatf("v%0d pcd", i),
                      pc_write_data, vecs[i].epd);
            end
        end

        // Fill every GPR with a distinct value, then read back on all ports
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            reset = 1'b0; we = 1'b1; sel = i[0];
            wa = 4'(i);
            mem_data   = 32'h1000_0000 + 32'(i) * 32'h0001_0001;
            alu_result = 32'h1000_0000 + 32'(i) * 32'h0001_0001;
        end
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 15; i++) begin
            rn_addr = 4'(i);
            rm_addr = 4'(14 - i);
            rs_addr = 4'((i + 1) % 15);
            #1;
            check($sformatf("fill rn%0d", i), rn_data,
                  32'h1000_0000 + 32'(i) * 32'h0001_0001);
            check($sformatf("fill rm%0d", 14 - i), rm_data,
                  32'h1000_0000 + 32'(14 - i) * 32'h0001_0001);
            check($sformatf("fill rs%0d", (i + 1) % 15), rs_data,
                  32'h1000_0000 + 32'((i + 1) % 15) * 32'h0001_0001);
        end
        check("fill pcv", {31'd0, pc_write_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
